apb_master_ctrl: RTL
====================

Name: apb_master_ctrl

Overview:
- APB requester-side controller that sequences single transfers onto up to NSLV APB completers, e.g. two instances of the team's 4-wait-state memory slave.
- Takes commands over a valid/ready interface and decodes the upper address bits to one PSEL.
- Drives the SETUP/ACCESS phases, waits for PREADY with a timeout, and returns read data or error over a valid/ready response interface.

Parameters:
- ADDWIDTH, 8, completer-local address width (PADDR width).
- DATAWIDTH, 32, data width; must be a multiple of 8.
- NSLV, 2, number of completers (1..4).
- SELW, 1, slave-select bits taken from the top of cmd_addr.
- TIMEOUT, 16, max ACCESS cycles without PREADY before abort (>=2).

Ports:
- PCLK  in  1  clock
- PRESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  SELW+ADDWIDTH  {slave select, local address}
- cmd_wdata  in  DATAWIDTH  write data
- cmd_strb  in  DATAWIDTH/8  byte strobes; forced to 0 on reads
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  DATAWIDTH  read data; 0 for writes and errors
- rsp_err  out  1  1 = decode error or timeout
- PSEL  out  NSLV  one-hot completer select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  direction
- PADDR  out  ADDWIDTH  local address
- PWDATA  out  DATAWIDTH  write data
- PSTRB  out  DATAWIDTH/8  strobes
- PREADY  in  NSLV  per-completer ready
- PRDATA  in  NSLV*DATAWIDTH  concatenated read data; completer i at [i*DATAWIDTH +: DATAWIDTH]

Behaviour:
- All state is registered on posedge PCLK.
- Reset (PRESETn=0 at an edge), which aborts any transfer in flight:
  - state=IDLE
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - timeout counter=0
- cmd_ready = (state==IDLE); it is combinational from the state register only.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - On cmd_valid, latch cmd_write, cmd_addr, cmd_wdata and the strobes into the APB output registers.
  - sel = cmd_addr[top SELW bits].
  - If sel < NSLV: PSEL[sel]=1, PENABLE=0, go to SETUP.
  - If sel >= NSLV (decode error): no bus cycle; rsp_err=1, rsp_rdata=0, rsp_valid=1, go to RESP.
- SETUP: lasts exactly one cycle. Set PENABLE=1, clear the counter, go to ACCESS.
- ACCESS:
  - PSEL, PENABLE, PADDR, PWRITE, PWDATA and PSTRB are held stable.
  - Each cycle with PREADY[sel]=0, increment the counter.
  - If PREADY[sel]=1: capture rsp_rdata = PWRITE ? 0 : PRDATA slice[sel]; rsp_err=0. Drop PSEL and PENABLE, set rsp_valid=1, go to RESP.
  - Else if the counter reaches TIMEOUT-1: abort. Drop PSEL and PENABLE, rsp_err=1, rsp_rdata=0, rsp_valid=1, go to RESP.
  - PREADY wins over timeout if both occur in the same cycle.
  - PREADY of unselected completers is ignored.
- RESP:
  - rsp_valid and the response data are held until rsp_ready.
  - On rsp_valid&rsp_ready, clear rsp_valid and go to IDLE.
  - The earliest next command is accepted in the following cycle (no back-to-back overlap).
- Latency, cmd accept to rsp_valid: 2 + N cycles, where N = ACCESS cycles up to and including the PREADY cycle.
  - Against the 4-wait-state slave, PREADY rises on the 5th ACCESS cycle: N=5, total 7.
  - Decode error: 1 cycle.
- The bus returns to idle (PSEL=0) for at least one cycle between transfers.
- The counter width is $clog2(TIMEOUT)+1 and saturates; it never wraps.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, SETUP, ACCESS, RESP}
  - default widths ADDWIDTH/DATAWIDTH
- Natural sub-module apb_slave_decode: combinational sel -> one-hot PSEL vector, plus an in-range flag and PREADY/PRDATA muxing.
- FSM, counter and registers stay in the top module.

Test Plan:
- Write: cmd addr 9'h010, wdata 32'hDEADBEEF, strb 4'hF, slave0 = 4-wait-state memory slave -> PSEL=2'b01 for 6 cycles (1 SETUP + 5 ACCESS). rsp_valid at accept+7 with rsp_err=0, rsp_rdata=0.
- Readback: read of 9'h010 -> rsp_rdata=32'hDEADBEEF, err=0. Then a write to 9'h110 of 32'h12345678 with strb 4'b0011, then a read of 9'h110 -> PSEL=2'b10 for both, rdata[15:0]=16'h5678.
- Timeout: slave1 PREADY stuck 0, TIMEOUT=16 -> PSEL dropped after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, next command accepted normally.
- Decode error: NSLV=1, SELW=1, cmd addr 9'h1FF -> PSEL never asserted, rsp_valid the cycle after accept with err=1.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/rdata stable, cmd_ready=0, PSEL=0. Release -> IDLE next cycle.
- Reset mid-ACCESS: PRESETn=0 on the 3rd ACCESS cycle -> next edge PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB requester-side controller.
package apb_pkg;

  // Transfer sequencing states of the requester.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  localparam int unsigned APB_ADDWIDTH  = 8;
  localparam int unsigned APB_DATAWIDTH = 32;

endpackage

// File: rtl/apb_slave_decode.sv
// Completer decode: turns a slave-select field into a one-hot PSEL vector
// with an in-range flag, and muxes PREADY/PRDATA of the active completer.
module apb_slave_decode
  import apb_pkg::*;
#(
  parameter int unsigned NSLV      = 2,
  parameter int unsigned SELW      = 1,
  parameter int unsigned DATAWIDTH = APB_DATAWIDTH
) (
  input  logic [SELW-1:0]           cmd_sel,
  input  logic [SELW-1:0]           bus_sel,
  input  logic [NSLV-1:0]           pready,
  input  logic [NSLV*DATAWIDTH-1:0] prdata,
  output logic [NSLV-1:0]           psel_onehot,
  output logic                      in_range,
  output logic                      pready_sel,
  output logic [DATAWIDTH-1:0]      prdata_sel
);

  // Decode the incoming select and mux the return path of the latched one;
  // responses from any other completer never reach the requester.
  always_comb begin
    psel_onehot = '0;
    pready_sel  = 1'b0;
    prdata_sel  = '0;
    in_range    = (32'(cmd_sel) < NSLV);
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (32'(cmd_sel) == i) begin
        psel_onehot[i] = 1'b1;
      end
      if (32'(bus_sel) == i) begin
        pready_sel = pready[i];
        prdata_sel = prdata[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester controller: accepts single commands over valid/ready,
// runs the SETUP/ACCESS phases on one decoded completer with a PREADY
// timeout, and returns read data or an error over valid/ready.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDWIDTH  = APB_ADDWIDTH,
  parameter int unsigned DATAWIDTH = APB_DATAWIDTH,
  parameter int unsigned NSLV      = 2,
  parameter int unsigned SELW      = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [SELW+ADDWIDTH-1:0]  cmd_addr,
  input  logic [DATAWIDTH-1:0]      cmd_wdata,
  input  logic [DATAWIDTH/8-1:0]    cmd_strb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATAWIDTH-1:0]      rsp_rdata,
  output logic                      rsp_err,
  output logic [NSLV-1:0]           PSEL,
  output logic                      PENABLE,
  output logic                      PWRITE,
  output logic [ADDWIDTH-1:0]       PADDR,
  output logic [DATAWIDTH-1:0]      PWDATA,
  output logic [DATAWIDTH/8-1:0]    PSTRB,
  input  logic [NSLV-1:0]           PREADY,
  input  logic [NSLV*DATAWIDTH-1:0] PRDATA
);

  localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  apb_state_e           state;
  logic [CW-1:0]        cnt;
  logic [SELW-1:0]      sel_q;
  logic [SELW-1:0]      cmd_sel;
  logic [NSLV-1:0]      sel_onehot;
  logic                 sel_ok;
  logic                 bus_ready;
  logic [DATAWIDTH-1:0] bus_rdata;

  assign cmd_sel   = cmd_addr[SELW+ADDWIDTH-1 -: SELW];
  assign cmd_ready = (state == IDLE);

  apb_slave_decode #(
    .NSLV      (NSLV),
    .SELW      (SELW),
    .DATAWIDTH (DATAWIDTH)
  ) u_decode (
    .cmd_sel     (cmd_sel),
    .bus_sel     (sel_q),
    .pready      (PREADY),
    .prdata      (PRDATA),
    .psel_onehot (sel_onehot),
    .in_range    (sel_ok),
    .pready_sel  (bus_ready),
    .prdata_sel  (bus_rdata)
  );

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PSTRB     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      sel_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr[ADDWIDTH-1:0];
            PWDATA <= cmd_wdata;
            PSTRB  <= cmd_write ? cmd_strb : '0;
            sel_q  <= cmd_sel;
            if (sel_ok) begin
              PSEL    <= sel_onehot;
              PENABLE <= 1'b0;
              state   <= SETUP;
            end else begin
              // No completer behind this select: answer without a bus cycle.
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          cnt     <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (bus_ready) begin
            rsp_rdata <= PWRITE ? '0 : bus_rdata;
            rsp_err   <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
            if (cnt == CNT_LAST) begin
              PSEL      <= '0;
              PENABLE   <= 1'b0;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
